qpu_dtcm_ctrl: RTL and testbench

DTCM access controller sitting directly upstream of the QPU DTCM SRAM wrapper. It arbitrates two valid/ready command masters: m0 is the QPU LSU and m1 is the external/debug bus. It generates the single-port SRAM strobes (cs/we/addr/wem/din) and returns one response per command, using the RAM's one-cycle read latency. It also owns the RAM low-power controls: light-sleep on idle, plus deep-sleep and shutdown pass-through.

---
 rtl/qpu_dtcm_ctrl.sv | 160 ++++++++++++++++
 tb/tb_qpu_dtcm_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_dtcm_ctrl.sv
// DTCM access controller: round-robin arbitration of the QPU LSU (m0) and the
// external/debug bus (m1) onto a single-port SRAM, plus light-sleep management.
module qpu_dtcm_ctrl #(
    parameter int AW          = 14,
    parameter int DW          = 32,
    parameter int MW          = 4,
    parameter int DP          = 16384,
    parameter int IDLE_THRESH = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_cmd_valid,
    output logic          m0_cmd_ready,
    input  logic          m0_cmd_read,
    input  logic [AW+1:0] m0_cmd_addr,
    input  logic [DW-1:0] m0_cmd_wdata,
    input  logic [MW-1:0] m0_cmd_wmask,
    output logic          m0_rsp_valid,
    input  logic          m0_rsp_ready,
    output logic [DW-1:0] m0_rsp_rdata,
    output logic          m0_rsp_err,

    input  logic          m1_cmd_valid,
    output logic          m1_cmd_ready,
    input  logic          m1_cmd_read,
    input  logic [AW+1:0] m1_cmd_addr,
    input  logic [DW-1:0] m1_cmd_wdata,
    input  logic [MW-1:0] m1_cmd_wmask,
    output logic          m1_rsp_valid,
    input  logic          m1_rsp_ready,
    output logic [DW-1:0] m1_rsp_rdata,
    output logic          m1_rsp_err,

    input  logic          pwr_sd,
    input  logic          pwr_ds,

    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    output logic          ram_sd,
    output logic          ram_ds,
    output logic          ram_ls,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [AW:0] DEPTH  = (AW+1)'(DP);
    localparam logic [7:0]  THRESH = 8'(IDLE_THRESH);

    logic          slot_valid;
    logic          slot_owner;
    logic          slot_pend;
    logic          slot_err;
    logic [DW-1:0] hold_rdata;
    logic          last_grant;
    logic [7:0]    idle_cnt;

    logic          any_valid;
    logic          owner_ready;
    logic          slot_free;
    logic          power_ok;
    logic          grant0;
    logic          grant1;
    logic          acc0;
    logic          acc1;
    logic          accept;
    logic          sel_read;
    logic [AW-1:0] sel_word;
    logic          in_range;
    logic [DW-1:0] rsp_data;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^{m0_cmd_addr[1:0], m1_cmd_addr[1:0]};

    // Each grant looks only at the other master's valid, so ready never depends on its own valid.
    always_comb begin
        any_valid    = m0_cmd_valid || m1_cmd_valid;
        owner_ready  = slot_owner ? m1_rsp_ready : m0_rsp_ready;
        slot_free    = !slot_valid || owner_ready;
        power_ok     = !pwr_sd && !pwr_ds && !ram_ls && !rst;
        grant0       = !m1_cmd_valid || last_grant;
        grant1       = !m0_cmd_valid || !last_grant;
        m0_cmd_ready = slot_free && power_ok && grant0;
        m1_cmd_ready = slot_free && power_ok && grant1;
        acc0         = m0_cmd_valid && m0_cmd_ready;
        acc1         = m1_cmd_valid && m1_cmd_ready;
        accept       = acc0 || acc1;

        sel_read = acc1 ? m1_cmd_read : m0_cmd_read;
        sel_word = acc1 ? m1_cmd_addr[AW+1:2] : m0_cmd_addr[AW+1:2];
        in_range = {1'b0, sel_word} < DEPTH;

        ram_cs   = accept && in_range;
        ram_we   = ram_cs && !sel_read;
        ram_addr = sel_word;
        ram_wem  = acc1 ? m1_cmd_wmask : m0_cmd_wmask;
        ram_din  = acc1 ? m1_cmd_wdata : m0_cmd_wdata;

        // ram_dout is only trustworthy in the first response cycle of a read.
        rsp_data     = slot_pend ? ram_dout : hold_rdata;
        m0_rsp_valid = slot_valid && !slot_owner;
        m1_rsp_valid = slot_valid && slot_owner;
        m0_rsp_rdata = m0_rsp_valid ? rsp_data : '0;
        m1_rsp_rdata = m1_rsp_valid ? rsp_data : '0;
        m0_rsp_err   = m0_rsp_valid && slot_err;
        m1_rsp_err   = m1_rsp_valid && slot_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= 1'b0;
            slot_owner <= 1'b0;
            slot_pend  <= 1'b0;
            slot_err   <= 1'b0;
            hold_rdata <= '0;
            last_grant <= 1'b1;
            idle_cnt   <= 8'd0;
            ram_ls     <= 1'b0;
            ram_sd     <= 1'b0;
            ram_ds     <= 1'b0;
        end else begin
            if (slot_pend) begin
                hold_rdata <= ram_dout;
                slot_pend  <= 1'b0;
            end
            if (slot_valid && owner_ready) begin
                slot_valid <= 1'b0;
            end
            // A new accept overrides both the capture and the pop above.
            if (accept) begin
                slot_valid <= 1'b1;
                slot_owner <= acc1;
                slot_pend  <= sel_read && in_range;
                slot_err   <= !in_range;
                hold_rdata <= '0;
                last_grant <= acc1;
            end

            if (any_valid || slot_valid) begin
                idle_cnt <= 8'd0;
            end else if (idle_cnt < THRESH) begin
                idle_cnt <= idle_cnt + 8'd1;
            end

            if (ram_ls) begin
                if (any_valid) begin
                    ram_ls <= 1'b0;
                end
            end else if (idle_cnt == THRESH && !any_valid && !slot_valid) begin
                ram_ls <= 1'b1;
            end

            ram_sd <= pwr_sd;
            ram_ds <= pwr_ds;
        end
    end

endmodule

// File: tb/tb_qpu_dtcm_ctrl.sv
// Directed self-checking bench for qpu_dtcm_ctrl with a simple one-cycle-latency
// SRAM model whose output is scrambled whenever no read is in progress.
module tb_qpu_dtcm_ctrl;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int DP = 8192;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
    logic [AW+1:0] m0_cmd_addr;
    logic [DW-1:0] m0_cmd_wdata;
    logic [MW-1:0] m0_cmd_wmask;
    logic          m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [DW-1:0] m0_rsp_rdata;
    logic          m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
    logic [AW+1:0] m1_cmd_addr;
    logic [DW-1:0] m1_cmd_wdata;
    logic [MW-1:0] m1_cmd_wmask;
    logic          m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [DW-1:0] m1_rsp_rdata;
    logic          pwr_sd, pwr_ds;
    logic          ram_cs, ram_we, ram_sd, ram_ds, ram_ls;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    qpu_dtcm_ctrl #(.AW(AW), .DW(DW), .MW(MW), .DP(DP), .IDLE_THRESH(8)) dut (
        .clk(clk), .rst(rst),
        .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_read(m0_cmd_read),
        .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
        .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
        .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_read(m1_cmd_read),
        .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
        .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
        .pwr_sd(pwr_sd), .pwr_ds(pwr_ds),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
        .ram_din(ram_din), .ram_sd(ram_sd), .ram_ds(ram_ds), .ram_ls(ram_ls),
        .ram_dout(ram_dout)
    );

    // SRAM model: masked byte writes, read data one cycle later, garbage otherwise.
    always @(posedge clk) begin
        if (ram_cs && ram_we) begin
            for (int b = 0; b < MW; b++) begin
                if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
            end
        end
        if (ram_cs && !ram_we) ram_dout <= mem[ram_addr];
        else                   ram_dout <= $urandom;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic apply_m0(input logic v, input logic rd, input logic [AW+1:0] a,
                            input logic [DW-1:0] wd, input logic [MW-1:0] wm);
        m0_cmd_valid = v; m0_cmd_read = rd; m0_cmd_addr = a;
        m0_cmd_wdata = wd; m0_cmd_wmask = wm;
    endtask

    task automatic apply_m1(input logic v, input logic rd, input logic [AW+1:0] a,
                            input logic [DW-1:0] wd, input logic [MW-1:0] wm);
        m1_cmd_valid = v; m1_cmd_read = rd; m1_cmd_addr = a;
        m1_cmd_wdata = wd; m1_cmd_wmask = wm;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; pwr_sd = 1'b0; pwr_ds = 1'b0;
        m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        apply_m0(1'b0, 1'b0, '0, '0, '0);
        apply_m1(1'b0, 1'b0, '0, '0, '0);

        next_cycle(); settle();
        check_bit("rst_m0_rsp_valid", m0_rsp_valid, 1'b0);
        check_bit("rst_m1_rsp_valid", m1_rsp_valid, 1'b0);
        check_word("rst_m0_rdata", m0_rsp_rdata, 32'h0);
        check_bit("rst_m0_err", m0_rsp_err, 1'b0);
        check_bit("rst_ram_we", ram_we, 1'b0);
        check_bit("rst_ram_ls", ram_ls, 1'b0);
        check_bit("rst_ram_sd", ram_sd, 1'b0);
        check_bit("rst_ram_ds", ram_ds, 1'b0);

        next_cycle(); apply_m0(1'b1, 1'b1, 16'h0010, '0, '0); settle();
        check_bit("rst_cycle_ram_cs", ram_cs, 1'b0);
        check_bit("rst_cycle_m0_ready", m0_cmd_ready, 1'b0);

        // write 0xDEADBEEF to 0x10 then read it back
        next_cycle(); rst = 1'b0; apply_m0(1'b1, 1'b0, 16'h0010, 32'hDEADBEEF, 4'hF); settle();
        check_bit("wr_m0_ready", m0_cmd_ready, 1'b1);
        check_bit("wr_ram_cs", ram_cs, 1'b1);
        check_bit("wr_ram_we", ram_we, 1'b1);
        check_word("wr_ram_addr", 32'(ram_addr), 32'd4);
        check_word("wr_ram_wem", 32'(ram_wem), 32'hF);
        check_word("wr_ram_din", ram_din, 32'hDEADBEEF);

        next_cycle(); apply_m0(1'b1, 1'b1, 16'h0010, '0, '0); settle();
        check_bit("wr_rsp_valid", m0_rsp_valid, 1'b1);
        check_bit("wr_rsp_err", m0_rsp_err, 1'b0);
        check_word("wr_rsp_rdata", m0_rsp_rdata, 32'h0);
        check_bit("wr_m1_rsp_valid", m1_rsp_valid, 1'b0);
        check_bit("rd_m0_ready", m0_cmd_ready, 1'b1);
        check_bit("rd_ram_we", ram_we, 1'b0);

        next_cycle(); apply_m0(1'b0, 1'b0, '0, '0, '0);
        apply_m1(1'b1, 1'b0, 16'h0040, 32'h12345678, 4'hF); settle();
        check_bit("rd_rsp_valid", m0_rsp_valid, 1'b1);
        check_word("rd_rsp_rdata", m0_rsp_rdata, 32'hDEADBEEF);
        check_bit("m1_wr_ready", m1_cmd_ready, 1'b1);
        check_word("m1_wr_addr", 32'(ram_addr), 32'd16);

        // both masters hold reads: grants alternate starting with m0
        apply_m0(1'b1, 1'b1, 16'h0010, '0, '0);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); apply_m1(1'b1, 1'b1, 16'h0040, '0, '0); settle();
            check_bit("arb_m0_ready", m0_cmd_ready, (i % 2) == 0);
            check_bit("arb_m1_ready", m1_cmd_ready, (i % 2) == 1);
            check_word("arb_ram_addr", 32'(ram_addr), (i % 2 == 0) ? 32'd4 : 32'd16);
            if (i == 0) begin
                check_bit("arb_m1_wr_rsp", m1_rsp_valid, 1'b1);
            end else if (i % 2 == 1) begin
                check_bit("arb_m0_rsp_valid", m0_rsp_valid, 1'b1);
                check_word("arb_m0_rdata", m0_rsp_rdata, 32'hDEADBEEF);
                check_bit("arb_m1_rsp_idle", m1_rsp_valid, 1'b0);
                check_word("arb_m1_rdata_zero", m1_rsp_rdata, 32'h0);
            end else begin
                check_bit("arb_m1_rsp_valid", m1_rsp_valid, 1'b1);
                check_word("arb_m1_rdata", m1_rsp_rdata, 32'h12345678);
            end
        end

        next_cycle(); apply_m0(1'b0, 1'b0, '0, '0, '0); apply_m1(1'b0, 1'b0, '0, '0, '0); settle();
        check_bit("arb_last_m1_rsp", m1_rsp_valid, 1'b1);
        check_word("arb_last_m1_rdata", m1_rsp_rdata, 32'h12345678);

        // full write, then mask-0 write to the same word (must not modify it)
        next_cycle(); apply_m0(1'b1, 1'b0, 16'h0020, 32'hCAFEF00D, 4'hF); settle();
        check_bit("w20_ready", m0_cmd_ready, 1'b1);
        next_cycle(); apply_m0(1'b1, 1'b0, 16'h0020, 32'hFFFFFFFF, 4'h0); settle();
        check_bit("mask0_ram_cs", ram_cs, 1'b1);
        check_word("mask0_ram_wem", 32'(ram_wem), 32'h0);
        check_bit("w20_rsp_valid", m0_rsp_valid, 1'b1);

        next_cycle(); apply_m0(1'b1, 1'b1, 16'h0020, '0, '0); settle();
        check_bit("r20_ready", m0_cmd_ready, 1'b1);
        check_bit("r20_ram_cs", ram_cs, 1'b1);

        // stalled read response must hold steady; no new accept meanwhile
        for (int i = 0; i < 5; i++) begin
            next_cycle(); m0_rsp_ready = 1'b0; apply_m0(1'b1, 1'b1, 16'h0010, '0, '0); settle();
            check_bit("stall_rsp_valid", m0_rsp_valid, 1'b1);
            check_word("stall_rdata", m0_rsp_rdata, 32'hCAFEF00D);
            check_bit("stall_no_ready", m0_cmd_ready, 1'b0);
            check_bit("stall_no_cs", ram_cs, 1'b0);
        end
        next_cycle(); m0_rsp_ready = 1'b1; settle();
        check_word("stall_release_rdata", m0_rsp_rdata, 32'hCAFEF00D);
        check_bit("stall_release_ready", m0_cmd_ready, 1'b1);

        // out-of-range accesses at word address DP and above
        next_cycle(); apply_m0(1'b1, 1'b1, 16'h8000, '0, '0); settle();
        check_word("after_stall_rdata", m0_rsp_rdata, 32'hDEADBEEF);
        check_bit("oor_rd_ready", m0_cmd_ready, 1'b1);
        check_bit("oor_rd_no_cs", ram_cs, 1'b0);
        next_cycle(); apply_m0(1'b1, 1'b0, 16'hFFFC, 32'h55555555, 4'hF); settle();
        check_bit("oor_rd_err", m0_rsp_err, 1'b1);
        check_word("oor_rd_rdata", m0_rsp_rdata, 32'h0);
        check_bit("oor_wr_no_cs", ram_cs, 1'b0);
        next_cycle(); apply_m0(1'b0, 1'b0, '0, '0, '0); settle();
        check_bit("oor_wr_err", m0_rsp_err, 1'b1);

        // power requests block access; ram_sd/ram_ds follow one cycle late
        next_cycle(); pwr_sd = 1'b1; apply_m0(1'b1, 1'b1, 16'h0010, '0, '0); settle();
        check_bit("sd_blocks_ready", m0_cmd_ready, 1'b0);
        check_bit("sd_blocks_cs", ram_cs, 1'b0);
        check_bit("sd_delayed", ram_sd, 1'b0);
        next_cycle(); pwr_sd = 1'b0; settle();
        check_bit("sd_registered", ram_sd, 1'b1);
        check_bit("sd_release_ready", m0_cmd_ready, 1'b1);
        next_cycle(); pwr_ds = 1'b1; apply_m0(1'b0, 1'b0, '0, '0, '0); settle();
        check_word("pwr_rd_rdata", m0_rsp_rdata, 32'hDEADBEEF);
        check_bit("ds_delayed", ram_ds, 1'b0);
        next_cycle(); pwr_ds = 1'b0; settle();
        check_bit("ds_registered", ram_ds, 1'b1);

        // light-sleep entry after idle cycles, then wake by an m1 read
        repeat (3) next_cycle();
        settle();
        check_bit("ls_not_yet", ram_ls, 1'b0);
        repeat (8) next_cycle();
        settle();
        check_bit("ls_entered", ram_ls, 1'b1);

        next_cycle(); apply_m1(1'b1, 1'b1, 16'h0040, '0, '0); settle();
        check_bit("wake_ls_still", ram_ls, 1'b1);
        check_bit("wake_no_ready", m1_cmd_ready, 1'b0);
        check_bit("wake_no_cs", ram_cs, 1'b0);
        next_cycle(); settle();
        check_bit("wake_ls_clear", ram_ls, 1'b0);
        check_bit("wake_ready", m1_cmd_ready, 1'b1);
        check_bit("wake_cs", ram_cs, 1'b1);
        next_cycle(); apply_m1(1'b0, 1'b0, '0, '0, '0); settle();
        check_bit("wake_rsp_valid", m1_rsp_valid, 1'b1);
        check_word("wake_rdata", m1_rsp_rdata, 32'h12345678);

        // reset while an m0 read response is stalled; m0 was granted last
        next_cycle(); m0_rsp_ready = 1'b0; apply_m0(1'b1, 1'b1, 16'h0020, '0, '0); settle();
        check_bit("pre_rst_ready", m0_cmd_ready, 1'b1);
        next_cycle(); apply_m0(1'b0, 1'b0, '0, '0, '0); settle();
        check_bit("pre_rst_stall", m0_rsp_valid, 1'b1);
        check_word("pre_rst_rdata", m0_rsp_rdata, 32'hCAFEF00D);
        next_cycle(); rst = 1'b1; apply_m1(1'b1, 1'b1, 16'h0040, '0, '0); settle();
        check_bit("mid_rst_no_cs", ram_cs, 1'b0);
        next_cycle(); rst = 1'b0; m0_rsp_ready = 1'b1;
        apply_m0(1'b1, 1'b1, 16'h0010, '0, '0); settle();
        check_bit("post_rst_m0_rsp", m0_rsp_valid, 1'b0);
        check_bit("post_rst_m1_rsp", m1_rsp_valid, 1'b0);
        check_bit("post_rst_m0_first", m0_cmd_ready, 1'b1);
        check_bit("post_rst_m1_wait", m1_cmd_ready, 1'b0);
        next_cycle(); settle();
        check_bit("post_rst_m1_next", m1_cmd_ready, 1'b1);
        check_word("post_rst_m0_rdata", m0_rsp_rdata, 32'hDEADBEEF);
        next_cycle(); apply_m0(1'b0, 1'b0, '0, '0, '0); apply_m1(1'b0, 1'b0, '0, '0, '0); settle();
        check_bit("post_rst_m1_rsp_valid", m1_rsp_valid, 1'b1);
        check_word("post_rst_m1_rdata", m1_rsp_rdata, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
